// File: rtl/flex_repacker_pkg.sv
// Shared types and sizing helpers for the flex_repacker chunk repacker.
// Widths are derived from IN/OUT so every file sizes its counters identically.
package flex_repacker_pkg;

    localparam int unsigned DEF_IN  = 3;
    localparam int unsigned DEF_OUT = 8;
    localparam int unsigned CHUNK_W = 8;

    typedef logic [CHUNK_W-1:0] chunk_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r++;
        return r;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        return (clog2(n) == 0) ? 1 : clog2(n);
    endfunction

    function automatic int unsigned buff_depth(input int unsigned in_n, input int unsigned out_n);
        return in_n + out_n - 1;
    endfunction

    function automatic int unsigned in_cnt_w(input int unsigned in_n);
        return clog2(in_n + 1);
    endfunction

    function automatic int unsigned out_cnt_w(input int unsigned out_n);
        return clog2(out_n + 1);
    endfunction

    // Occupancy counter width; covers 0..BUFF.
    function automatic int unsigned lvl_w(input int unsigned in_n, input int unsigned out_n);
        return clog2(in_n + out_n);
    endfunction

endpackage

// File: rtl/flex_repacker_if.sv
// Input-beat and output-word handshake bundle for flex_repacker.
// master drives beats and o_rdy; slave is the repacker itself.
interface flex_repacker_if import flex_repacker_pkg::*; #(
    parameter int unsigned IN  = DEF_IN,
    parameter int unsigned OUT = DEF_OUT,
    parameter int unsigned W   = CHUNK_W
) ();
    localparam int unsigned ICW = in_cnt_w(IN);
    localparam int unsigned OCW = out_cnt_w(OUT);

    logic              i_val;
    logic              i_rdy;
    logic [W*IN-1:0]   i_data;
    logic [ICW-1:0]    i_cnt;
    logic              i_last;
    logic              o_val;
    logic              o_rdy;
    logic [W*OUT-1:0]  o_data;
    logic [OCW-1:0]    o_cnt;
    logic              o_last;

    modport master (
        output i_val, i_data, i_cnt, i_last, o_rdy,
        input  i_rdy, o_val, o_data, o_cnt, o_last
    );

    modport slave (
        input  i_val, i_data, i_cnt, i_last, o_rdy,
        output i_rdy, o_val, o_data, o_cnt, o_last
    );
endinterface

// File: rtl/flex_repacker_merge.sv
// Combinational next-state for the chunk buffer: optional shift-down by OUT
// on pop, then append the accepted chunks at the new fill point.
module flex_repacker_merge import flex_repacker_pkg::*; #(
    parameter int unsigned IN  = DEF_IN,
    parameter int unsigned OUT = DEF_OUT,
    parameter int unsigned W   = CHUNK_W,
    localparam int unsigned BUFF = buff_depth(IN, OUT),
    localparam int unsigned VW   = lvl_w(IN, OUT),
    localparam int unsigned ICW  = in_cnt_w(IN),
    localparam int unsigned AW   = idx_w(BUFF)
) (
    input  logic [W-1:0]    mem_i [BUFF],
    input  logic [VW-1:0]   v_i,
    input  logic [W*IN-1:0] data_i,
    input  logic [ICW-1:0]  cnt_i,
    input  logic            push_i,
    input  logic            pop_i,
    output logic [W-1:0]    mem_o [BUFF],
    output logic [VW-1:0]   v_o
);

    always_comb begin
        int unsigned v_base;
        int unsigned n_in;
        int unsigned src;
        v_base = 32'(v_i);
        // A pop drains min(v, OUT), so the fill point never goes negative.
        if (pop_i) v_base = (v_base > OUT) ? v_base - OUT : 0;
        n_in = push_i ? 32'(cnt_i) : 0;
        src  = 0;
        for (int unsigned p = 0; p < BUFF; p++) begin
            mem_o[p] = '0;
            src = pop_i ? p + OUT : p;
            if (p < v_base && src < BUFF) mem_o[p] = mem_i[AW'(src)];
            for (int unsigned k = 0; k < IN; k++) begin
                if (k < n_in && p == v_base + k) mem_o[p] = data_i[k*W +: W];
            end
        end
        v_o = VW'(v_base + n_in);
    end

endmodule

// File: rtl/flex_repacker.sv
// Variable-count chunk repacker: 1..IN chunks per beat in, OUT-chunk words out.
// Define FLEX_REPACKER_FLUSH_EN to enable i_last flushing of partial words.
module flex_repacker import flex_repacker_pkg::*; #(
    parameter int unsigned IN  = DEF_IN,
    parameter int unsigned OUT = DEF_OUT,
    parameter int unsigned W   = CHUNK_W,
    localparam int unsigned BUFF = buff_depth(IN, OUT),
    localparam int unsigned VW   = lvl_w(IN, OUT),
    localparam int unsigned ICW  = in_cnt_w(IN),
    localparam int unsigned OCW  = out_cnt_w(OUT)
) (
    input  logic                clk,
    input  logic                rst,
    flex_repacker_if.slave      bus,
    output logic [VW-1:0]       level
);

    logic [W-1:0]     mem_q [BUFF];
    logic [W-1:0]     mem_d [BUFF];
    logic [VW-1:0]    v_q, v_d;
    logic             pend_q, pend_d;
    logic             push, pop;
    logic             i_rdy, o_val, o_last;
    logic [OCW-1:0]   o_cnt;
    logic [W*OUT-1:0] o_data;
    logic [ICW-1:0]   cnt_c;

    // i_rdy assumes a full IN-chunk beat so it never depends on i_cnt.
    always_comb begin
        int unsigned v_i;
        v_i    = 32'(v_q);
        o_val  = (v_i >= OUT) || pend_q;
        o_last = pend_q && (v_i <= OUT);
        o_cnt  = OCW'((v_i < OUT) ? v_i : OUT);
        pop    = o_val && bus.o_rdy;
        i_rdy  = !pend_q && (v_i + IN <= (pop ? BUFF + OUT : BUFF));
        push   = bus.i_val && i_rdy;
        cnt_c  = (32'(bus.i_cnt) > IN) ? ICW'(IN) : bus.i_cnt;
    end

    flex_repacker_merge #(
        .IN  (IN),
        .OUT (OUT),
        .W   (W)
    ) u_merge (
        .mem_i  (mem_q),
        .v_i    (v_q),
        .data_i (bus.i_data),
        .cnt_i  (cnt_c),
        .push_i (push),
        .pop_i  (pop),
        .mem_o  (mem_d),
        .v_o    (v_d)
    );

    always_comb begin
        pend_d = 1'b0;
`ifdef FLEX_REPACKER_FLUSH_EN
        pend_d = pend_q;
        if (push && bus.i_last) pend_d = 1'b1;
        if (pop && o_last)      pend_d = 1'b0;
`endif
    end

`ifndef FLEX_REPACKER_FLUSH_EN
    logic unused_last;
    assign unused_last = bus.i_last;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q  <= '{default: '0};
            v_q    <= '0;
            pend_q <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            v_q    <= v_d;
            pend_q <= pend_d;
        end
    end

    // Slots at or above v are always zero, so the low OUT slots read out directly.
    always_comb begin
        o_data = '0;
        for (int unsigned c = 0; c < OUT; c++) o_data[c*W +: W] = mem_q[c];
    end

    assign bus.i_rdy  = i_rdy;
    assign bus.o_val  = o_val;
    assign bus.o_data = o_data;
    assign bus.o_cnt  = o_cnt;
    assign bus.o_last = o_last;
    assign level      = v_q;

`ifndef SYNTHESIS
    a_cnt_range: assert property (@(posedge clk) disable iff (rst)
        bus.i_val |-> (32'(bus.i_cnt) <= IN));
    a_out_hold: assert property (@(posedge clk) disable iff (rst)
        (o_val && !bus.o_rdy) |=> (o_val && $stable(o_data) && $stable(o_cnt)));
`endif

endmodule
